// File: rtl/relay_pulse_sequencer.sv
// Latching-relay H-bridge coil sequencer: one set/reset command at a time, fixed pulse then dead time.
// Optional build macro RELAY_SKIP_REDUNDANT_EN: commands matching the tracked relay state finish without a pulse.
module relay_pulse_sequencer #(
    parameter int unsigned NUM_RELAYS   = 4,
    parameter int unsigned PULSE_CYCLES = 1250000,
    parameter int unsigned DEAD_CYCLES  = 125000,
    parameter int unsigned IDX_WIDTH    = 2
) (
    input  logic                  clk_125mhz,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic [IDX_WIDTH-1:0]  cmd_relay,
    input  logic                  cmd_dir,
    output logic                  cmd_ready,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [NUM_RELAYS-1:0] relay_a,
    output logic [NUM_RELAYS-1:0] relay_b,
    output logic [NUM_RELAYS-1:0] relay_state,
    output logic [NUM_RELAYS-1:0] state_known
);

    localparam int unsigned MAX_CYCLES = (PULSE_CYCLES > DEAD_CYCLES) ? PULSE_CYCLES : DEAD_CYCLES;
    localparam int unsigned CNT_LOG2   = $clog2(MAX_CYCLES);
    localparam int unsigned CNT_WIDTH  = (CNT_LOG2 < 1) ? 1 : CNT_LOG2;
    localparam logic [CNT_WIDTH-1:0] PULSE_LOAD = CNT_WIDTH'(PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DEAD_LOAD  = CNT_WIDTH'(DEAD_CYCLES - 1);

`ifdef RELAY_SKIP_REDUNDANT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_DEAD   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;
`endif

    state_t                state_q;
    state_t                state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [IDX_WIDTH-1:0]  idx_d;
    logic                  dir_q;
    logic                  dir_d;
    logic                  in_range;
    logic [NUM_RELAYS-1:0] cmd_sel;
    logic [NUM_RELAYS-1:0] idx_sel;
    logic [NUM_RELAYS-1:0] drv_sel;
    logic [NUM_RELAYS-1:0] relay_state_d;
    logic [NUM_RELAYS-1:0] state_known_d;
    logic [NUM_RELAYS-1:0] relay_a_d;
    logic [NUM_RELAYS-1:0] relay_b_d;
    logic                  done_d;
    logic                  err_d;
`ifdef RELAY_SKIP_REDUNDANT_EN
    logic                  redundant;
`endif

    // Next-state, counter, tracked-state and drive decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        dir_d         = dir_q;
        relay_state_d = relay_state;
        state_known_d = state_known;
        done_d        = 1'b0;
        err_d         = 1'b0;
        cmd_sel       = '0;
        idx_sel       = '0;
        drv_sel       = '0;
        relay_a_d     = '0;
        relay_b_d     = '0;

        in_range = (32'(cmd_relay) < NUM_RELAYS);
        for (int unsigned i = 0; i < NUM_RELAYS; i++) begin
            cmd_sel[i] = (32'(cmd_relay) == i);
            idx_sel[i] = (32'(idx_q) == i);
        end
`ifdef RELAY_SKIP_REDUNDANT_EN
        redundant = |(cmd_sel & state_known & ~(relay_state ^ {NUM_RELAYS{cmd_dir}}));
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (!in_range) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
`ifdef RELAY_SKIP_REDUNDANT_EN
                    else if (redundant) begin
                        state_d = ST_FINISH;
                    end
`endif
                    else begin
                        state_d = ST_PULSE;
                        cnt_d   = PULSE_LOAD;
                        idx_d   = cmd_relay;
                        dir_d   = cmd_dir;
                    end
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d       = ST_DEAD;
                    cnt_d         = DEAD_LOAD;
                    relay_state_d = dir_q ? (relay_state | idx_sel) : (relay_state & ~idx_sel);
                    state_known_d = state_known | idx_sel;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_DEAD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
`ifdef RELAY_SKIP_REDUNDANT_EN
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Drive bits follow the next state only, so the registered pins never glitch.
        for (int unsigned i = 0; i < NUM_RELAYS; i++) begin
            drv_sel[i] = (32'(idx_d) == i);
        end
        if (state_d == ST_PULSE) begin
            relay_a_d = dir_d ? drv_sel : '0;
            relay_b_d = dir_d ? '0 : drv_sel;
        end
    end

    // State and registered outputs; reset drops coil drive immediately.
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            dir_q       <= 1'b0;
            relay_a     <= '0;
            relay_b     <= '0;
            relay_state <= '0;
            state_known <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dir_q       <= dir_d;
            relay_a     <= relay_a_d;
            relay_b     <= relay_b_d;
            relay_state <= relay_state_d;
            state_known <= state_known_d;
            done        <= done_d;
            err         <= err_d;
            busy        <= (state_d != ST_IDLE);
            cmd_ready   <= (state_d == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_relay_pulse_sequencer.sv
// Directed bench for relay_pulse_sequencer: timeline model of accepted commands checked every cycle,
// plus hand-computed literal checks at key cycles. Honours RELAY_SKIP_REDUNDANT_EN when defined.
module tb_relay_pulse_sequencer;

    localparam int NR = 3;
    localparam int P  = 10;
    localparam int D  = 4;
    localparam int IW = 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [IW-1:0] cmd_relay = '0;
    logic          cmd_dir   = 1'b0;
    logic          cmd_ready;
    logic          done;
    logic          err;
    logic          busy;
    logic [NR-1:0] relay_a;
    logic [NR-1:0] relay_b;
    logic [NR-1:0] relay_state;
    logic [NR-1:0] state_known;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    relay_pulse_sequencer #(
        .NUM_RELAYS  (NR),
        .PULSE_CYCLES(P),
        .DEAD_CYCLES (D),
        .IDX_WIDTH   (IW)
    ) dut (
        .clk_125mhz (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_relay  (cmd_relay),
        .cmd_dir    (cmd_dir),
        .cmd_ready  (cmd_ready),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .relay_a    (relay_a),
        .relay_b    (relay_b),
        .relay_state(relay_state),
        .state_known(state_known)
    );

    // Model: edges are counted; an accepted command at edge N defines every output window.
    int          edge_cnt  = 0;
    int          free_at   = 0;
    int          pulse_n   = -100;
    int          pulse_idx = 0;
    bit          pulse_dir = 1'b0;
    int          done_edge = -100;
    int          err_edge  = -100;
    int          upd_edge  = -100;
    bit [NR-1:0] m_state   = '0;
    bit [NR-1:0] m_known   = '0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got 0x%0h, want 0x%0h", nm, edge_cnt, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [IW-1:0] idx, input logic dir);
        cmd_valid = 1'b1;
        cmd_relay = idx;
        cmd_dir   = dir;
        step(1);
        cmd_valid = 1'b0;
        step(P + D);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_at   = 0;
            pulse_n   = -100;
            done_edge = -100;
            err_edge  = -100;
            upd_edge  = -100;
            m_state   = '0;
            m_known   = '0;
        end else begin
            edge_cnt++;
            if (edge_cnt == upd_edge) begin
                m_state[pulse_idx] = pulse_dir;
                m_known[pulse_idx] = 1'b1;
            end
            if (cmd_valid && edge_cnt >= free_at) begin
                if (int'(cmd_relay) >= NR) begin
                    done_edge = edge_cnt;
                    err_edge  = edge_cnt;
                    free_at   = edge_cnt + 1;
                end
`ifdef RELAY_SKIP_REDUNDANT_EN
                else if (m_known[cmd_relay] && m_state[cmd_relay] == cmd_dir) begin
                    done_edge = edge_cnt + 1;
                    free_at   = edge_cnt + 2;
                end
`endif
                else begin
                    pulse_n   = edge_cnt;
                    pulse_idx = int'(cmd_relay);
                    pulse_dir = cmd_dir;
                    upd_edge  = edge_cnt + P;
                    done_edge = edge_cnt + P + D;
                    free_at   = edge_cnt + P + D + 1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare_proc
        logic [NR-1:0] ea;
        logic [NR-1:0] eb;
        bit            ready_e;
        bit            in_pulse;
        ready_e  = (edge_cnt + 1 >= free_at);
        in_pulse = (edge_cnt >= pulse_n) && (edge_cnt <= pulse_n + P - 1);
        ea = (in_pulse && pulse_dir)  ? NR'(1 << pulse_idx) : '0;
        eb = (in_pulse && !pulse_dir) ? NR'(1 << pulse_idx) : '0;
        cmp("cmd_ready",   32'(cmd_ready),   32'(ready_e));
        cmp("busy",        32'(busy),        32'(!ready_e));
        cmp("done",        32'(done),        32'(edge_cnt == done_edge));
        cmp("err",         32'(err),         32'(edge_cnt == err_edge));
        cmp("relay_a",     32'(relay_a),     32'(ea));
        cmp("relay_b",     32'(relay_b),     32'(eb));
        cmp("relay_state", 32'(relay_state), 32'(m_state));
        cmp("state_known", 32'(state_known), 32'(m_known));
        cmp("drive_onehot", 32'($countones(relay_a | relay_b) <= 1), 32'd1);
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        step(3);
        cmp("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        cmp("rst_busy",      32'(busy),      32'd0);
        cmp("rst_done",      32'(done),      32'd0);
        cmp("rst_relay_a",   32'(relay_a),   32'b0);
        cmp("rst_known",     32'(state_known), 32'b0);
        rst_n = 1'b1;
        step(3);

        // Relay 2 set, with relay 0 reset held behind it
        cmd_valid = 1'b1;
        cmd_relay = 2'd2;
        cmd_dir   = 1'b1;
        step(1);
        cmd_relay = 2'd0;
        cmd_dir   = 1'b0;
        cmp("a2_first",     32'(relay_a),   32'b100);
        cmp("b_during_a2",  32'(relay_b),   32'b0);
        cmp("ready_busy",   32'(cmd_ready), 32'd0);
        step(9);
        cmp("a2_last",      32'(relay_a),   32'b100);
        step(1);
        cmp("a2_off",       32'(relay_a),   32'b0);
        cmp("state2_set",   32'(relay_state[2]), 32'd1);
        cmp("known2_set",   32'(state_known[2]), 32'd1);
        step(4);
        cmp("a2_done",      32'(done),      32'd1);
        cmp("a2_done_rdy",  32'(cmd_ready), 32'd1);
        step(1);
        cmd_valid = 1'b0;
        cmp("b0_first",     32'(relay_b),   32'b001);
        cmp("a_during_b0",  32'(relay_a),   32'b0);
        step(9);
        cmp("b0_last",      32'(relay_b),   32'b001);
        step(1);
        cmp("b0_off",       32'(relay_b),   32'b0);
        step(4);
        cmp("b0_done",      32'(done),      32'd1);

        // Out-of-range index: immediate done+err, no drive
        cmd_valid = 1'b1;
        cmd_relay = 2'd3;
        cmd_dir   = 1'b1;
        step(1);
        cmd_valid = 1'b0;
        cmp("oor_done",     32'(done),        32'd1);
        cmp("oor_err",      32'(err),         32'd1);
        cmp("oor_drive",    32'(relay_a | relay_b), 32'b0);
        cmp("oor_state",    32'(relay_state), 32'b100);
        step(1);
        cmp("oor_err_off",  32'(err),         32'd0);

        // Repeat relay 2 set: skipped when redundancy suppression is built in
        cmd_valid = 1'b1;
        cmd_relay = 2'd2;
        cmd_dir   = 1'b1;
        step(1);
        cmd_valid = 1'b0;
`ifdef RELAY_SKIP_REDUNDANT_EN
        cmp("skip_no_drive", 32'(relay_a),  32'b0);
        cmp("skip_busy",     32'(busy),     32'd1);
        step(1);
        cmp("skip_done",     32'(done),     32'd1);
        step(13);
`else
        cmp("repeat_first",  32'(relay_a),  32'b100);
        step(9);
        cmp("repeat_last",   32'(relay_a),  32'b100);
        step(5);
        cmp("repeat_done",   32'(done),     32'd1);
`endif

        // Back-to-back commands toggling tracked state
        run_cmd(2'd1, 1'b1);
        run_cmd(2'd1, 1'b0);
        run_cmd(2'd0, 1'b1);
        cmp("seq_state",    32'(relay_state), 32'b101);
        cmp("seq_known",    32'(state_known), 32'b111);

        // Reset in the middle of a pulse
        cmd_valid = 1'b1;
        cmd_relay = 2'd1;
        cmd_dir   = 1'b1;
        step(1);
        cmd_valid = 1'b0;
        cmp("a1_first",     32'(relay_a),   32'b010);
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("mid_rst_a",     32'(relay_a),     32'b0);
        cmp("mid_rst_known", 32'(state_known), 32'b0);
        cmp("mid_rst_state", 32'(relay_state), 32'b0);
        cmp("mid_rst_ready", 32'(cmd_ready),   32'd1);
        step(2);
        rst_n = 1'b1;
        step(1);
        cmd_valid = 1'b1;
        cmd_relay = 2'd0;
        cmd_dir   = 1'b1;
        step(1);
        cmd_valid = 1'b0;
        cmp("post_rst_a0",  32'(relay_a),   32'b001);
        step(P + D);
        cmp("post_rst_done",  32'(done),        32'd1);
        cmp("post_rst_known", 32'(state_known), 32'b001);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
